mem_port_arbiter: RTL and testbench

Arbiter that shares the single-port unified instruction/data memory (32 x 32-bit, synchronous read, write-or-read per cycle) between the pipeline's instruction-fetch stage and its MEM stage. It grants at most one access per cycle, routes the one-cycle-late read data back to the requester that issued it, and generates the stall for the losing requester. Data accesses normally win, and a starvation counter guarantees fetch progress. A saturating conflict counter is exported for debug.

---
 rtl/mem_port_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 51 +++++
 tb/tb_mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// mem_port_if: fetch, data and memory-side signals of the unified memory port.
interface mem_port_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_stall;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        output d_gnt, d_stall, d_done, d_rdata, mem_we, mem_addr, mem_din
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        input  d_gnt, d_stall, d_done, d_rdata, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and the MEM stage.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX denials.
module mem_port_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_port_if.slave   bus,
    output logic [15:0] conflict_cnt
);
    typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_D_RD, RESP_D_WR} resp_t;
    resp_t       resp_sel, resp_next;
    logic [3:0]  starve_cnt, starve_next;
    logic [15:0] conflict_next;
    logic        force_if, d_win, f_win;
    assign force_if = starve_cnt == 4'(STARVE_MAX);
    assign d_win    = rst_n & bus.d_req & ~force_if;
    assign f_win    = rst_n & bus.if_req & ~(bus.d_req & ~force_if);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sel     <= RESP_NONE;
            starve_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            resp_sel     <= resp_next;
            starve_cnt   <= starve_next;
            conflict_cnt <= conflict_next;
        end
    end
    always_comb begin
        resp_next     = d_win ? (bus.d_we ? RESP_D_WR : RESP_D_RD) : f_win ? RESP_IF : RESP_NONE;
        starve_next   = (!bus.if_req || f_win) ? 4'd0 : force_if ? starve_cnt : 4'(starve_cnt + 4'd1);
        conflict_next = (bus.if_req & bus.d_req & ~&conflict_cnt) ? 16'(conflict_cnt + 16'd1) : conflict_cnt;
    end
    // The memory output is shared; consumers qualify it with if_rvalid / d_done.
    always_comb begin
        bus.if_gnt    = f_win;
        bus.d_gnt     = d_win;
        bus.if_stall  = bus.if_req & ~f_win;
        bus.d_stall   = bus.d_req & ~d_win;
        bus.mem_we    = d_win & bus.d_we;
        bus.mem_addr  = d_win ? bus.d_addr : f_win ? bus.if_addr : {ADDR_W{1'b0}};
        bus.mem_din   = d_win ? bus.d_wdata : {DATA_W{1'b0}};
        bus.if_rvalid = resp_sel == RESP_IF;
        bus.d_done    = resp_sel == RESP_D_RD || resp_sel == RESP_D_WR;
        bus.if_rdata  = bus.mem_dout;
        bus.d_rdata   = bus.mem_dout;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written reset, starvation and saturation sequences.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] conflict_cnt;
    logic [31:0] ram [32];
    int          n_checks = 0;
    int          n_fail = 0;

    mem_port_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, output holds on a write.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        else bus.mem_dout <= ram[bus.mem_addr];
    end

    typedef struct {
        logic        ir;
        logic [4:0]  ia;
        logic        dr;
        logic        dw;
        logic [4:0]  da;
        logic [31:0] dd;
        logic        ig;
        logic        dg;
        logic        rv;
        logic        dn;
        logic        ck;
        logic [31:0] rd;
        logic [15:0] cc;
    } vec_t;

    vec_t tv [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [4:0] ia, input logic dr, input logic dw,
                         input logic [4:0] da, input logic [31:0] dd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 32'h1000_0000 + i;
        bus.mem_dout = '0;
        tv[0]  = '{1, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0,             0};
        tv[1]  = '{1, 1, 0, 0, 0, 0,             1, 0, 1, 0, 1, 32'h1000_0000, 0};
        tv[2]  = '{1, 2, 0, 0, 0, 0,             1, 0, 1, 0, 1, 32'h1000_0001, 0};
        tv[3]  = '{0, 0, 0, 0, 0, 0,             0, 0, 1, 0, 1, 32'h1000_0002, 0};
        tv[4]  = '{0, 0, 1, 1, 22, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0,             0};
        tv[5]  = '{0, 0, 1, 0, 22, 0,            0, 1, 0, 1, 0, 0,             0};
        tv[6]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 1, 1, 32'hDEADBEEF,  0};
        tv[7]  = '{1, 3, 1, 0, 5, 0,             0, 1, 0, 0, 0, 0,             0};
        tv[8]  = '{1, 3, 1, 0, 5, 0,             0, 1, 0, 1, 1, 32'h1000_0005, 1};
        tv[9]  = '{1, 3, 1, 0, 5, 0,             0, 1, 0, 1, 1, 32'h1000_0005, 2};
        tv[10] = '{1, 3, 0, 0, 0, 0,             1, 0, 0, 1, 1, 32'h1000_0005, 3};
        tv[11] = '{0, 0, 0, 0, 0, 0,             0, 0, 1, 0, 1, 32'h1000_0003, 3};

        // Reset held with both requests active: nothing may be granted or written.
        drive(1, 4, 1, 1, 7, 32'h1234_5678);
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_if_gnt", 32'(bus.if_gnt), 0);
            check("rst_d_gnt", 32'(bus.d_gnt), 0);
            check("rst_mem_we", 32'(bus.mem_we), 0);
            check("rst_conflict", 32'(conflict_cnt), 0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_d_gnt", 32'(bus.d_gnt), 1);
        check("rel_if_gnt", 32'(bus.if_gnt), 0);

        // Table: fetch stream, write-then-read, conflict with late fetch grant.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
            #1;
            check($sformatf("v%0d_if_gnt", i), 32'(bus.if_gnt), 32'(tv[i].ig));
            check($sformatf("v%0d_d_gnt", i), 32'(bus.d_gnt), 32'(tv[i].dg));
            check($sformatf("v%0d_if_stall", i), 32'(bus.if_stall), 32'(tv[i].ir & ~tv[i].ig));
            check($sformatf("v%0d_d_stall", i), 32'(bus.d_stall), 32'(tv[i].dr & ~tv[i].dg));
            check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(tv[i].dg & tv[i].dw));
            check($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr),
                  32'(tv[i].dg ? tv[i].da : tv[i].ig ? tv[i].ia : 5'd0));
            check($sformatf("v%0d_mem_din", i), bus.mem_din, tv[i].dg ? tv[i].dd : 32'd0);
            check($sformatf("v%0d_if_rvalid", i), 32'(bus.if_rvalid), 32'(tv[i].rv));
            check($sformatf("v%0d_d_done", i), 32'(bus.d_done), 32'(tv[i].dn));
            check($sformatf("v%0d_conflict", i), 32'(conflict_cnt), 32'(tv[i].cc));
            if (tv[i].ck) begin
                check($sformatf("v%0d_rdata", i), tv[i].rv ? bus.if_rdata : bus.d_rdata, tv[i].rd);
            end
        end

        // Starvation: continuous conflict gives D,D,D,D,IF repeating.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(1, 1, 1, 0, 0, 0);
            #1;
            check($sformatf("st%0d_if_gnt", k), 32'(bus.if_gnt), 32'(k % 5 == 4));
            check($sformatf("st%0d_d_gnt", k), 32'(bus.d_gnt), 32'(k % 5 != 4));
            check($sformatf("st%0d_starve", k), 32'(dut.starve_cnt), 32'(k % 5));
        end

        // Saturation of the conflict counter.
        do_reset();
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 0);
        repeat (70000) @(posedge clk);
        @(negedge clk); #1;
        check("sat_conflict", 32'(conflict_cnt), 32'h0000_FFFF);

        // Reset during a fetch read drops the response and clears the counters.
        drive(1, 2, 0, 0, 0, 0);
        #1;
        check("mid_if_gnt", 32'(bus.if_gnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_gnt_forced", 32'(bus.if_gnt), 0);
        @(negedge clk); #1;
        check("mid_rvalid", 32'(bus.if_rvalid), 0);
        check("mid_conflict", 32'(conflict_cnt), 0);
        check("mid_starve", 32'(dut.starve_cnt), 0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rvalid", 32'(bus.if_rvalid), 0);
        check("post_done", 32'(bus.d_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
